// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver:
// scan FSM states and the active-low hex glyph table.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index is the nibble value; bit 0 is segment a, bit 6 is segment g.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Host-side and pin-side signals of the seven-segment scan driver,
// bundled so the datapath and the board wiring see one port.
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digitsIn;
  logic [NUM_DIGITS-1:0]   dpIn;
  logic                    updateReq;
  logic                    lzSuppress;
  logic [6:0]              segOutL;
  logic                    dpOutL;
  logic [NUM_DIGITS-1:0]   digitSelL;
  logic                    updatePending;
  logic                    frameDone;

  modport master (
    output enable, digitsIn, dpIn, updateReq, lzSuppress,
    input  segOutL, dpOutL, digitSelL, updatePending, frameDone
  );

  modport slave (
    input  enable, digitsIn, dpIn, updateReq, lzSuppress,
    output segOutL, dpOutL, digitSelL, updatePending, frameDone
  );
endinterface

// File: rtl/seg7_scan_mux_onehot_dec.sv
// Generic N-to-2^N active-high one-hot decoder with enable; all outputs
// are low while disabled.
module onehot_dec #(
  parameter int N = 2
) (
  input  logic [N-1:0]      i_sel,
  input  logic              i_en,
  output logic [(2**N)-1:0] o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_en) begin
      o_dec[i_sel] = 1'b1;
    end else begin
      o_dec = '0;
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode seven-segment driver with anti-ghost
// blanking, leading-zero suppression and frame-synchronous data commit.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           resetL,
  seg7_scan_mux_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int DEC_W = 2 ** IDX_W;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             r_state;
  scan_state_t             w_next_state;
  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_dig;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_pend_dig;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_upd_pend;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_frame_done;

  logic                    w_slot_end;
  logic                    w_boundary;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_supp;
  logic                    w_show;
  logic [3:0]              w_nib;
  logic [DEC_W-1:0]        w_dec;
  logic [6:0]              w_seg_d;
  logic                    w_dp_d;
  logic [NUM_DIGITS-1:0]   w_sel_d;

  assign w_slot_end = bus.enable && (r_state == ST_SHOW) && (r_pre == PRE_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!bus.enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = HAS_BLANK ? ST_BLANK : ST_SHOW;
        ST_BLANK: begin
          if (r_pre == BLANK_LAST) begin
            w_next_state = ST_SHOW;
          end else begin
            w_next_state = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (r_pre == PRE_LAST) begin
            w_next_state = HAS_BLANK ? ST_BLANK : ST_SHOW;
          end else begin
            w_next_state = ST_SHOW;
          end
        end
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // Prescaler runs through the whole slot (blank + show); index steps at slot end.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (!bus.enable || (r_state == ST_IDLE)) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // The commit at a boundary reads the old pending value, so a capture on that
  // same edge survives as the next pending update.
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      r_pend_dig <= '0;
      r_pend_dp  <= '0;
      r_act_dig  <= '0;
      r_act_dp   <= '0;
      r_upd_pend <= 1'b0;
    end else begin
      if (bus.updateReq) begin
        r_pend_dig <= bus.digitsIn;
        r_pend_dp  <= bus.dpIn;
      end
      if (w_boundary && r_upd_pend) begin
        r_act_dig <= r_pend_dig;
        r_act_dp  <= r_pend_dp;
      end
      if (bus.updateReq) begin
        r_upd_pend <= 1'b1;
      end else if (w_boundary) begin
        r_upd_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_supp     = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_act_dig[4*k +: 4] == 4'h0);
      if (k != 0) begin
        w_supp[k] = bus.lzSuppress && w_zero_run;
      end else begin
        w_supp[k] = 1'b0;
      end
    end
  end

  assign w_nib  = r_act_dig[{r_idx, 2'b00} +: 4];
  assign w_show = bus.enable && (r_state == ST_SHOW) && !w_supp[r_idx];

  onehot_dec #(
    .N (IDX_W)
  ) u_dec (
    .i_sel (r_idx),
    .i_en  (w_show),
    .o_dec (w_dec)
  );

  always_comb begin
    if (w_show) begin
      w_seg_d = hex_to_seg(w_nib);
      w_dp_d  = ~r_act_dp[r_idx];
    end else begin
      w_seg_d = SEG_OFF;
      w_dp_d  = 1'b1;
    end
    w_sel_d = ~w_dec[NUM_DIGITS-1:0];
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_sel        <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_d;
      r_dp         <= w_dp_d;
      r_sel        <= w_sel_d;
      r_frame_done <= w_boundary;
    end
  end

  assign bus.segOutL       = r_seg;
  assign bus.dpOutL        = r_dp;
  assign bus.digitSelL     = r_sel;
  assign bus.updatePending = r_upd_pend;
  assign bus.frameDone     = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2 (8-cycle slots, 32-cycle frames).
module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic resetL;

  seg7_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_mux #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk    (clk),
    .resetL (resetL),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      drive;
    logic [3:0]      dp_on;
  } vec_t;

  vec_t vecs [9];

  // Observed pins packed as {sel[12:9], seg[8:2], dpL[1], frameDone[0]}.
  function automatic logic [31:0] obs();
    return {19'b0, bus.digitSelL, bus.segOutL, bus.dpOutL, bus.frameDone};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input logic [31:0] mask);
    n_checks++;
    if (((act ^ exp) & mask) !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (mask %h)", name, act, exp, mask);
    end
  endtask

  task automatic pulse(input logic [15:0] d, input logic [3:0] dp);
    bus.digitsIn  = d;
    bus.dpIn      = dp;
    bus.updateReq = 1'b1;
    @(negedge clk);
    bus.updateReq = 1'b0;
  endtask

  task automatic wait_fd(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.frameDone !== 1'b1 && cycles < 64);
    n_checks++;
    if (bus.frameDone !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frameDone got 0 after %0d cycles, expected 1", tag, cycles);
    end
  endtask

  // Checks the 32 samples following a frameDone sample; optional pulses.
  task automatic check_frame(input string tag, input logic [3:0][6:0] seg,
                             input logic [3:0] drive, input logic [3:0] dp_on,
                             input int pa_at, input logic [15:0] pa_dig,
                             input int pb_at, input logic [15:0] pb_dig,
                             input logic pend31, input logic pend32);
    int k;
    int pos;
    logic fd;
    logic [3:0] sel_e;
    logic [31:0] e;
    logic [31:0] m;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      k   = (c - 1) / 8;
      pos = (c - 1) % 8;
      fd  = (c == 32);
      m   = 32'h1FFF;
      sel_e = ~(4'b0001 << k);
      if (pos < 2) begin
        e = {19'b0, 4'hF, 7'h7F, 1'b1, fd};
      end else if (drive[k]) begin
        e = {19'b0, sel_e, seg[k], ~dp_on[k], fd};
      end else begin
        e = {19'b0, 4'hF, 7'h7F, 1'b1, fd};
        m = 32'h1E03;
      end
      chk($sformatf("%s c%0d", tag, c), obs(), e, m);
      if (c == 31) chk({tag, " pend31"}, 32'(bus.updatePending), 32'(pend31), 32'h1);
      if (c == 32) chk({tag, " pend32"}, 32'(bus.updatePending), 32'(pend32), 32'h1);
      if ((pa_at > 0 && c == pa_at + 1) || (pb_at > 0 && c == pb_at + 1))
        bus.updateReq = 1'b0;
      if (pa_at > 0 && c == pa_at) begin
        bus.digitsIn = pa_dig; bus.dpIn = 4'h0; bus.updateReq = 1'b1;
      end
      if (pb_at > 0 && c == pb_at) begin
        bus.digitsIn = pb_dig; bus.dpIn = 4'h0; bus.updateReq = 1'b1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [3:0][6:0] s1234;
    logic [3:0][6:0] sabcd;
    logic [3:0][6:0] s0050;
    logic [3:0][6:0] s5555;
    logic [3:0][6:0] s0000;
    s1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    sabcd = {7'h08, 7'h03, 7'h46, 7'h21};
    s0050 = {7'h40, 7'h40, 7'h12, 7'h40};
    s5555 = {7'h12, 7'h12, 7'h12, 7'h12};
    s0000 = {7'h40, 7'h40, 7'h40, 7'h40};

    vecs[0] = '{16'h1234, 4'h0, 1'b0, s1234, 4'hF, 4'h0};
    vecs[1] = '{16'h0050, 4'h0, 1'b1, s0050, 4'h3, 4'h0};
    vecs[2] = '{16'h0050, 4'h0, 1'b0, s0050, 4'hF, 4'h0};
    vecs[3] = '{16'hABCD, 4'h5, 1'b0, sabcd, 4'hF, 4'h5};
    vecs[4] = '{16'h0000, 4'h0, 1'b1, s0000, 4'h1, 4'h0};
    vecs[5] = '{16'hF0E8, 4'h0, 1'b1, {7'h0E, 7'h40, 7'h06, 7'h00}, 4'hF, 4'h0};
    vecs[6] = '{16'h0007, 4'h9, 1'b1, {7'h40, 7'h40, 7'h40, 7'h78}, 4'h1, 4'h9};
    vecs[7] = '{16'h9876, 4'h0, 1'b0, {7'h10, 7'h00, 7'h78, 7'h02}, 4'hF, 4'h0};
    vecs[8] = '{16'h1234, 4'h0, 1'b0, s1234, 4'hF, 4'h0};

    resetL         = 1'b0;
    bus.enable     = 1'b1;
    bus.digitsIn   = 16'h0;
    bus.dpIn       = 4'h0;
    bus.updateReq  = 1'b0;
    bus.lzSuppress = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset pins %0d", i), obs(), {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0}, 32'h1FFF);
      chk($sformatf("reset pend %0d", i), 32'(bus.updatePending), 32'h0, 32'h1);
    end
    resetL = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus.lzSuppress = vecs[i].lz;
      pulse(vecs[i].digits, vecs[i].dp);
      chk($sformatf("vec%0d pend set", i), 32'(bus.updatePending), 32'h1, 32'h1);
      wait_fd($sformatf("vec%0d boundary", i), cyc);
      chk($sformatf("vec%0d pend clr", i), 32'(bus.updatePending), 32'h0, 32'h1);
      check_frame($sformatf("vec%0d", i), vecs[i].seg, vecs[i].drive, vecs[i].dp_on,
                  0, 16'h0, 0, 16'h0, 1'b0, 1'b0);
    end

    bus.lzSuppress = 1'b0;
    check_frame("mid-upd", s1234, 4'hF, 4'h0, 10, 16'hABCD, 0, 16'h0, 1'b1, 1'b0);
    check_frame("last-wins", sabcd, 4'hF, 4'h0, 5, 16'h9876, 12, 16'h0050, 1'b1, 1'b0);
    check_frame("collide", s0050, 4'hF, 4'h0, 10, 16'hABCD, 31, 16'h5555, 1'b1, 1'b1);
    check_frame("after-collide", sabcd, 4'hF, 4'h0, 0, 16'h0, 0, 16'h0, 1'b1, 1'b0);
    check_frame("second-commit", s5555, 4'hF, 4'h0, 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);

    for (int c = 1; c <= 20; c++) @(negedge clk);
    chk("drop before", obs(), {19'b0, 4'b1011, 7'h12, 1'b1, 1'b0}, 32'h1FFF);
    bus.enable = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("drop off %0d", c), obs(), {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0}, 32'h1FFF);
    end
    bus.enable = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c >= 4 && c <= 9)
        chk($sformatf("resume c%0d", c), obs(), {19'b0, 4'b1110, 7'h12, 1'b1, 1'b0}, 32'h1FFF);
      else
        chk($sformatf("resume c%0d", c), obs(), {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0}, 32'h1FFF);
    end
    wait_fd("resume boundary", cyc);
    chk("resume frame length", 32'(cyc), 32'd22, 32'hFFFF_FFFF);

    pulse(16'h9876, 4'h0);
    chk("pre-reset pend", 32'(bus.updatePending), 32'h1, 32'h1);
    for (int c = 2; c <= 4; c++) @(negedge clk);
    chk("pre-reset show", obs(), {19'b0, 4'b1110, 7'h12, 1'b1, 1'b0}, 32'h1FFF);
    resetL = 1'b0;
    #1;
    chk("async reset pins", obs(), {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0}, 32'h1FFF);
    chk("async reset pend", 32'(bus.updatePending), 32'h0, 32'h1);
    @(negedge clk);
    resetL = 1'b1;
    wait_fd("post-reset boundary", cyc);
    check_frame("post-reset", s0000, 4'hF, 4'h0, 0, 16'h0, 0, 16'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
